// File: rtl/blimp_mem_pkg.sv
// blimp_mem_pkg: shared definitions for the BLIMP memory servers.
// Holds the request/response op encoding and the default message field widths.
// Each server builds its own mem_msg struct from these widths, so the message
// layout {op, addr, data, opaque} follows whatever the instance is configured for.
package blimp_mem_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

  localparam int c_addr_bits = 32;
  localparam int c_data_bits = 32;
  localparam int c_opaq_bits = 8;

endpackage

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo: response queue for the memory servers.
// Circular buffer of p_depth entries with separate full/empty flags. An enqueue
// and a dequeue may happen on the same edge, including when the queue is full.
// Read and write pointers wrap modulo p_depth, so the depth need not be a power of 2.
module mem_resp_fifo #(
  parameter int  p_depth = 4,
  parameter type msg_t   = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic enq,
  input  msg_t enq_msg,
  input  logic deq,
  output msg_t head,
  output logic full,
  output logic empty
);

  localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_bits = $clog2(p_depth + 1);

  msg_t                  slots [p_depth];
  logic [c_ptr_bits-1:0] wr_ptr;
  logic [c_ptr_bits-1:0] rd_ptr;
  logic [c_cnt_bits-1:0] count;
  logic                  do_enq;
  logic                  do_deq;

  function automatic logic [c_ptr_bits-1:0] bump(input logic [c_ptr_bits-1:0] ptr);
    return (ptr == c_ptr_bits'(p_depth - 1)) ? '0 : ptr + c_ptr_bits'(1);
  endfunction

  assign full   = (count == c_cnt_bits'(p_depth));
  assign empty  = (count == '0);
  assign do_deq = deq && !empty;
  assign do_enq = enq && (!full || do_deq);
  assign head   = slots[rd_ptr];

  // Payload storage: no reset needed because count gates what is visible.
  always_ff @(posedge clk) begin
    if (do_enq) slots[wr_ptr] <= enq_msg;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= bump(wr_ptr);
      if (do_deq) rd_ptr <= bump(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   count <= count + c_cnt_bits'(1);
        2'b01:   count <= count - c_cnt_bits'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_server.sv
// inst_mem_server: instruction-store server for the fetch client port.
// Requests access the word array on the accept edge, then travel through a
// fixed-latency valid-tagged pipeline into an in-order response queue. A
// credit counter limits accepted-but-undelivered requests to the queue depth,
// so the queue can never overflow.
// Configuration macro BLIMP_IMEM_WRITE_EN: when defined, writes update the
// array; when undefined the array is read-only and writes are answered with
// the currently stored word. The array has no reset and is meant to be
// preloaded by the harness.
module inst_mem_server
  import blimp_mem_pkg::*;
#(
  parameter int p_addr_bits    = c_addr_bits,
  parameter int p_data_bits    = c_data_bits,
  parameter int p_opaq_bits    = c_opaq_bits,
  parameter int p_mem_words    = 1024,
  parameter int p_latency      = 2,
  parameter int p_resp_q_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_addr_bits-1:0] req_addr,
  input  logic [p_data_bits-1:0] req_data,
  input  logic [p_opaq_bits-1:0] req_opaque,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_addr_bits-1:0] resp_addr,
  output logic [p_data_bits-1:0] resp_data,
  output logic [p_opaq_bits-1:0] resp_opaque
);

  localparam int c_idx_bits = $clog2(p_mem_words);
  localparam int c_cnt_bits = $clog2(p_resp_q_depth + 1);
  localparam int c_last     = p_latency - 1;

`ifdef BLIMP_IMEM_WRITE_EN
  localparam logic c_write_en = 1'b1;
`else
  localparam logic c_write_en = 1'b0;
`endif

  typedef struct packed {
    mem_op_t                op;
    logic [p_addr_bits-1:0] addr;
    logic [p_data_bits-1:0] data;
    logic [p_opaq_bits-1:0] opaque;
  } mem_msg_t;

  logic [p_data_bits-1:0] mem [p_mem_words];
  logic [c_idx_bits-1:0]  word_idx;
  logic                   req_fire;
  logic                   resp_fire;
  logic [c_cnt_bits-1:0]  in_flight;
  mem_msg_t               stage0_msg;
  logic [p_latency-1:0]   pipe_val;
  mem_msg_t               pipe_msg [p_latency];
  mem_msg_t               fifo_head;
  mem_msg_t               resp_msg;
  logic                   fifo_enq;
  logic                   fifo_deq;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign word_idx  = req_addr[c_idx_bits+1:2];
  assign req_rdy   = !rst && (in_flight < c_cnt_bits'(p_resp_q_depth));
  assign req_fire  = req_val && req_rdy;

  // The queue head has priority; an empty queue lets the last stage through directly.
  assign resp_val  = !fifo_empty || pipe_val[c_last];
  assign resp_msg  = fifo_empty ? pipe_msg[c_last] : fifo_head;
  assign resp_fire = resp_val && resp_rdy;
  assign fifo_deq  = resp_rdy && !fifo_empty;
  assign fifo_enq  = pipe_val[c_last] && !(fifo_empty && resp_rdy)
                     && !(fifo_full && !fifo_deq);

  assign resp_op     = resp_msg.op;
  assign resp_addr   = resp_msg.addr;
  assign resp_data   = resp_msg.data;
  assign resp_opaque = resp_msg.opaque;

  // Build the stage-0 entry; idle slots carry all-zero payload so outputs rest at 0.
  always_comb begin
    stage0_msg = '0;
    if (req_fire) begin
      stage0_msg.op     = mem_op_t'(req_op);
      stage0_msg.addr   = req_addr;
      stage0_msg.data   = (req_op && c_write_en) ? req_data : mem[word_idx];
      stage0_msg.opaque = req_opaque;
    end
  end

  // Storage update on the accept edge; reset deliberately leaves contents alone.
  always_ff @(posedge clk) begin
    if (req_fire && req_op && c_write_en) mem[word_idx] <= req_data;
  end

  // Latency pipeline: shifts every cycle and never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_val <= '0;
      for (int i = 0; i < p_latency; i++) pipe_msg[i] <= '0;
    end else begin
      pipe_val[0] <= req_fire;
      pipe_msg[0] <= stage0_msg;
      for (int i = 1; i < p_latency; i++) begin
        pipe_val[i] <= pipe_val[i-1];
        pipe_msg[i] <= pipe_msg[i-1];
      end
    end
  end

  // Credit counter: accepted requests whose responses have not yet been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   in_flight <= in_flight + c_cnt_bits'(1);
        2'b01:   in_flight <= in_flight - c_cnt_bits'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  mem_resp_fifo #(
    .p_depth (p_resp_q_depth),
    .msg_t   (mem_msg_t)
  ) resp_q (
    .clk     (clk),
    .rst     (rst),
    .enq     (fifo_enq),
    .enq_msg (pipe_msg[c_last]),
    .deq     (fifo_deq),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_inst_mem_server.sv
// tb_inst_mem_server: directed bench for inst_mem_server with default parameters
// (latency 2, queue depth 4, 1024 words). Expected data depends on whether
// BLIMP_IMEM_WRITE_EN is defined for the build.
module tb_inst_mem_server;

`ifdef BLIMP_IMEM_WRITE_EN
  localparam bit c_wen = 1'b1;
`else
  localparam bit c_wen = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  req_opaque;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_op;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;
  logic [7:0]  resp_opaque;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  opaque;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] burst_addr [4];
  logic [31:0] burst_exp  [4];
  int          accepted;
  logic        fire;

  inst_mem_server dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_opaque  (req_opaque),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_op     (resp_op),
    .resp_addr   (resp_addr),
    .resp_data   (resp_data),
    .resp_opaque (resp_opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all request-side inputs plus resp_rdy in one go.
  task automatic applyStimulus(input logic val, input logic op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [7:0] opq,
                               input logic rrdy);
    req_val    = val;
    req_op     = op;
    req_addr   = addr;
    req_data   = data;
    req_opaque = opq;
    resp_rdy   = rrdy;
  endtask

  // Compare one observed value with its required value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with storage preloaded by the harness.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    dut.mem[0]    = 32'h11111111;
    dut.mem[4]    = 32'hDEADBEEF;
    dut.mem[5]    = 32'h0BADF00D;
    dut.mem[8]    = 32'hCAFEF00D;
    dut.mem[16]   = 32'h0F0F0F0F;
    dut.mem[1023] = 32'hA5A5A5A5;
    #2;
    checkOutput("rdy_in_reset", req_rdy, 0);
    checkOutput("val_in_reset", resp_val, 0);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rdy_after_reset", req_rdy, 1);
      checkOutput("val_after_reset", resp_val, 0);
      checkOutput("data_after_reset", resp_data, 0);
      checkOutput("opq_after_reset", resp_opaque, 0);
      nextCycle();
    end

    // Single-request vectors: latency, data, echo fields, address wrap.
    vecs[0] = '{1'b0, 32'h00000010, 32'h0,        8'h5A, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h00000020, 32'h0,        8'h01, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 32'h00000020, 32'h12345678, 8'h02, c_wen ? 32'h12345678 : 32'hCAFEF00D};
    vecs[3] = '{1'b0, 32'h00000020, 32'h0,        8'h03, c_wen ? 32'h12345678 : 32'hCAFEF00D};
    vecs[4] = '{1'b0, 32'h00001010, 32'h0,        8'h04, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 32'h00000013, 32'h0,        8'h05, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 32'h00000FFC, 32'h0,        8'h06, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 32'h00000000, 32'h0,        8'h07, 32'h11111111};
    vecs[8] = '{1'b1, 32'h00000014, 32'h55AA55AA, 8'h08, c_wen ? 32'h55AA55AA : 32'h0BADF00D};
    vecs[9] = '{1'b0, 32'h00000014, 32'h0,        8'h09, c_wen ? 32'h55AA55AA : 32'h0BADF00D};

    for (int v = 0; v < 10; v++) begin
      applyStimulus(1'b1, vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].opaque, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_req_rdy", v), req_rdy, 1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_not_early", v), resp_val, 0);
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d_resp_val", v), resp_val, 1);
      checkOutput($sformatf("v%0d_resp_data", v), resp_data, vecs[v].exp_data);
      checkOutput($sformatf("v%0d_resp_opaque", v), resp_opaque, vecs[v].opaque);
      checkOutput($sformatf("v%0d_resp_op", v), resp_op, vecs[v].op);
      checkOutput($sformatf("v%0d_resp_addr", v), resp_addr, vecs[v].addr);
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("v%0d_drained", v), resp_val, 0);
      nextCycle();
    end

    // Write immediately followed by a read of the same word.
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h87654321, 8'h10, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 8'h11, 1'b1);
    @(negedge clk);
    checkOutput("b2b_not_early", resp_val, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_wr_val", resp_val, 1);
    checkOutput("b2b_wr_op", resp_op, 1);
    checkOutput("b2b_wr_opq", resp_opaque, 8'h10);
    checkOutput("b2b_wr_data", resp_data, c_wen ? 32'h87654321 : 32'h0F0F0F0F);
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_rd_val", resp_val, 1);
    checkOutput("b2b_rd_op", resp_op, 0);
    checkOutput("b2b_rd_opq", resp_opaque, 8'h11);
    checkOutput("b2b_rd_data", resp_data, c_wen ? 32'h87654321 : 32'h0F0F0F0F);
    nextCycle();
    @(negedge clk);
    checkOutput("b2b_drained", resp_val, 0);
    nextCycle();

    // Back-pressure: fill all credits, then drain in order.
    burst_addr[0] = 32'h0;   burst_exp[0] = 32'h11111111;
    burst_addr[1] = 32'h10;  burst_exp[1] = 32'hDEADBEEF;
    burst_addr[2] = 32'h40;  burst_exp[2] = c_wen ? 32'h87654321 : 32'h0F0F0F0F;
    burst_addr[3] = 32'hFFC; burst_exp[3] = 32'hA5A5A5A5;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, burst_addr[accepted & 3], 32'h0,
                    8'h20 + 8'(accepted & 3), 1'b0);
      @(negedge clk);
      fire = req_rdy;
      nextCycle();
      if (fire) accepted++;
    end
    checkOutput("burst_accepted", 32'(accepted), 4);
    @(negedge clk);
    checkOutput("burst_rdy_full", req_rdy, 0);
    checkOutput("burst_val_held", resp_val, 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("burst%0d_val", i), resp_val, 1);
      checkOutput($sformatf("burst%0d_opq", i), resp_opaque, 8'h20 + 8'(i));
      checkOutput($sformatf("burst%0d_data", i), resp_data, burst_exp[i]);
      if (i == 0) checkOutput("burst_rdy_on_deq", req_rdy, 0);
      if (i == 1) checkOutput("burst_rdy_back", req_rdy, 1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("burst_drained", resp_val, 0);
    checkOutput("burst_rdy_idle", req_rdy, 1);
    nextCycle();

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 8'h40 + 8'(i), 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b0);
    checkOutput("pre_reset_val", resp_val, 1);
    rst = 1'b1;
    #1;
    checkOutput("reset_val_now", resp_val, 0);
    checkOutput("reset_rdy_now", req_rdy, 0);
    nextCycle();
    rst = 1'b0;
    resp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("no_stale_%0d", i), resp_val, 0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 8'h77, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("post_reset_val", resp_val, 1);
    checkOutput("post_reset_opq", resp_opaque, 8'h77);
    checkOutput("post_reset_data", resp_data, c_wen ? 32'h12345678 : 32'hCAFEF00D);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
